// File: rtl/seven_seg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_mux_driver
// Purpose  : Time-multiplexed N-digit hex 7-segment driver with ghost-suppression
//            guard ticks and frame-coherent value updates.
//            Optional macro: SEG_LEADING_ZERO_BLANK_EN (leading-zero blanking).
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_mux_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLKS_PER_DIGIT = 25000,
   parameter int GUARD_CLKS     = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   input  logic                    i_Load,
   input  logic [4*NUM_DIGITS-1:0] i_Value,
   output logic [6:0]              o_Segment,
   output logic [NUM_DIGITS-1:0]   o_Digit_En,
   output logic                    o_Pending,
   output logic                    o_Frame_Done
);

   localparam int TICK_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
   localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [TICK_W-1:0]     LAST_TICK  = TICK_W'(CLKS_PER_DIGIT - 1);
   localparam logic [TICK_W-1:0]     GUARD_TICK = TICK_W'(GUARD_CLKS);
   localparam logic [SLOT_W-1:0]     LAST_SLOT  = SLOT_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_UNLIT  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_IDLE   = (DIG_ACTIVE_LOW != 0) ?
                                                  {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [TICK_W-1:0]       tick;
   logic [SLOT_W-1:0]       slot;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] display;
   logic [3:0]              nibbles [NUM_DIGITS];

   logic                    tick_wrap;
   logic                    frame_end;
   logic                    in_guard;
   logic                    blank_sel;
   logic [6:0]              seg_hi;
   logic [6:0]              seg_next;
   logic [NUM_DIGITS-1:0]   dig_hot;
   logic [NUM_DIGITS-1:0]   dig_next;

   // Active-high {A,B,C,D,E,F,G} pattern for a hex nibble.
   function automatic logic [6:0] encode_hex(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h7E;
         4'h1:    seg = 7'h30;
         4'h2:    seg = 7'h6D;
         4'h3:    seg = 7'h79;
         4'h4:    seg = 7'h33;
         4'h5:    seg = 7'h5B;
         4'h6:    seg = 7'h5F;
         4'h7:    seg = 7'h70;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h7B;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h1F;
         4'hC:    seg = 7'h4E;
         4'hD:    seg = 7'h3D;
         4'hE:    seg = 7'h4F;
         default: seg = 7'h47;
      endcase
      return seg;
   endfunction

   generate
      for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
         assign nibbles[i] = display[4*i +: 4];
      end
   endgenerate

   assign tick_wrap = (tick == LAST_TICK);
   assign frame_end = tick_wrap && (slot == LAST_SLOT);

   // Enables stay off for the first GUARD_CLKS ticks so the segment bus can settle.
   generate
      if (GUARD_CLKS > 0) begin : g_guard
         assign in_guard = (tick < GUARD_TICK);
      end else begin : g_no_guard
         assign in_guard = 1'b0;
      end
   endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] blank_mask;
   logic                  zero_above;

   // Walk down from the top digit; a digit blanks only while everything above it is zero.
   always_comb begin
      blank_mask = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above    = zero_above & (nibbles[i] == 4'h0);
         blank_mask[i] = zero_above;
      end
   end

   assign blank_sel = blank_mask[slot];
`else
   assign blank_sel = 1'b0;
`endif

   assign seg_hi   = blank_sel ? 7'h00 : encode_hex(nibbles[slot]);
   assign seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
   assign dig_hot  = in_guard ? {NUM_DIGITS{1'b0}} : (NUM_DIGITS'(1) << slot);
   assign dig_next = (DIG_ACTIVE_LOW != 0) ? ~dig_hot : dig_hot;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         tick <= '0;
         slot <= '0;
      end else if (tick_wrap) begin
         tick <= '0;
         slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
      end else begin
         tick <= tick + 1'b1;
      end
   end

   // Display only moves at the frame boundary; a coincident load lands in shadow
   // and keeps o_Pending set for the following frame.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         shadow    <= '0;
         display   <= '0;
         o_Pending <= 1'b0;
      end else begin
         if (frame_end && o_Pending) begin
            display <= shadow;
         end
         if (i_Load) begin
            shadow    <= i_Value;
            o_Pending <= 1'b1;
         end else if (frame_end) begin
            o_Pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Segment    <= SEG_UNLIT;
         o_Digit_En   <= DIG_IDLE;
         o_Frame_Done <= 1'b0;
      end else begin
         o_Segment    <= seg_next;
         o_Digit_En   <= dig_next;
         o_Frame_Done <= frame_end;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_mux_driver
// Purpose  : Directed self-checking bench for seven_seg_mux_driver (4 digits,
//            8 clocks per slot, 2 guard clocks, active-low outputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_mux_driver;

   localparam int ND    = 4;
   localparam int CPD   = 8;
   localparam int GUARD = 2;
   localparam int FRAME = ND * CPD;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        load  = 1'b0;
   logic [15:0] value = 16'h0000;
   logic [6:0]  segment;
   logic [3:0]  digit_en;
   logic        pending;
   logic        frame_done;

   int          n_checks = 0;
   int          n_fails  = 0;
   int          cyc      = 0;
   logic [6:0]  slot_seg;
   logic [6:0]  sweep_seg [4];

   always #5 clk = ~clk;

   seven_seg_mux_driver #(
      .NUM_DIGITS    (ND),
      .CLKS_PER_DIGIT(CPD),
      .GUARD_CLKS    (GUARD),
      .SEG_ACTIVE_LOW(1),
      .DIG_ACTIVE_LOW(1)
   ) dut (
      .i_Clk       (clk),
      .i_Rst       (rst),
      .i_Load      (load),
      .i_Value     (value),
      .o_Segment   (segment),
      .o_Digit_En  (digit_en),
      .o_Pending   (pending),
      .o_Frame_Done(frame_done)
   );

   // Edges since reset release; outputs seen after edge k describe scan position k-1.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to the negedge whose outputs describe (slot, tick) of the scan.
   task automatic goto(input int slot, input int tick);
      int target = slot * CPD + tick;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (cyc >= 1 && ((cyc - 1) % FRAME) == target) return;
      end
      check_value("goto_timeout", 0, 1);
   endtask

   task automatic pulse_load(input logic [15:0] v);
      value = v;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   // Active-low pattern of a zero digit; leading zeros go dark when blanking is built in.
   function automatic logic [6:0] zero_digit(input bit leading);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      return leading ? 7'h7F : 7'h01;
`else
      return 7'h01;
`endif
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g;
      int tk;
      int sl;

      // Reset values; load is held high to show it is ignored under reset.
      rst   = 1'b1;
      load  = 1'b1;
      value = 16'hBEEF;
      repeat (3) @(negedge clk);
      check_value("rst_seg", segment, 7'h7F);
      check_value("rst_en", digit_en, 4'hF);
      check_value("rst_pending", pending, 1'b0);
      check_value("rst_fdone", frame_done, 1'b0);
      load = 1'b0;
      rst  = 1'b0;

      // First 40 scan positions: guard timing, digit order, frame pulse, zero display.
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         g  = (cyc - 1) % FRAME;
         tk = g % CPD;
         sl = g / CPD;
         check_value("scan_en", digit_en, (tk < GUARD) ? 4'hF : (~(4'b0001 << sl) & 4'hF));
         check_value("scan_fdone", frame_done, (g == FRAME - 1));
         check_value("scan_seg", segment, (sl == 0) ? 7'h01 : zero_digit(1'b1));
         check_value("scan_pending", pending, 1'b0);
      end

      // Mid-frame load of 1A3F: pending until boundary, current frame untouched.
      goto(1, 3);
      pulse_load(16'h1A3F);
      check_value("load_pending", pending, 1'b1);
      goto(2, 4);
      check_value("load_same_frame_seg", segment, zero_digit(1'b1));
      check_value("load_same_frame_en", digit_en, 4'hB);
      goto(3, 6);
      check_value("load_pending_late", pending, 1'b1);
      goto(3, 7);
      check_value("adopt_fdone", frame_done, 1'b1);
      check_value("adopt_pending", pending, 1'b0);
      goto(0, 4);
      check_value("1A3F_d0", segment, 7'h38);
      check_value("1A3F_en0", digit_en, 4'hE);
      goto(1, 1);
      check_value("1A3F_guard_en", digit_en, 4'hF);
      goto(1, 4);
      check_value("1A3F_d1", segment, 7'h06);
      check_value("1A3F_en1", digit_en, 4'hD);
      goto(2, 4);
      check_value("1A3F_d2", segment, 7'h08);
      goto(3, 4);
      check_value("1A3F_d3", segment, 7'h4F);
      check_value("1A3F_en3", digit_en, 4'h7);

      // 1234 pending, then 0008 loaded on the boundary edge itself.
      goto(1, 2);
      pulse_load(16'h1234);
      goto(3, 6);
      value = 16'h0008;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      check_value("bnd_fdone", frame_done, 1'b1);
      check_value("bnd_pending_kept", pending, 1'b1);
      goto(0, 4);
      check_value("1234_d0", segment, 7'h4C);
      goto(1, 4);
      check_value("1234_d1", segment, 7'h06);
      goto(2, 4);
      check_value("1234_d2", segment, 7'h12);
      goto(3, 4);
      check_value("1234_d3", segment, 7'h4F);
      goto(3, 7);
      check_value("bnd_pending_clear", pending, 1'b0);
      goto(0, 4);
      check_value("0008_d0", segment, 7'h00);
      goto(1, 4);
      check_value("0008_d1", segment, zero_digit(1'b1));
      goto(2, 4);
      check_value("0008_d2", segment, zero_digit(1'b1));
      goto(3, 4);
      check_value("0008_d3", segment, zero_digit(1'b1));

      // Asynchronous reset in slot 2 with a value still pending.
      goto(1, 3);
      pulse_load(16'h5555);
      goto(2, 4);
      check_value("pre_rst_pending", pending, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_value("async_seg", segment, 7'h7F);
      check_value("async_en", digit_en, 4'hF);
      check_value("async_pending", pending, 1'b0);
      check_value("async_fdone", frame_done, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_value("restart_guard_en", digit_en, 4'hF);
      check_value("restart_seg", segment, 7'h01);
      goto(0, 4);
      check_value("restart_en0", digit_en, 4'hE);
      goto(3, 7);
      check_value("restart_pending", pending, 1'b0);
      goto(1, 4);
      check_value("restart_lost_value", segment, zero_digit(1'b1));

      // Three-frame sweep showing 2B7D.
      pulse_load(16'h2B7D);
      goto(3, 7);
      sweep_seg[0] = 7'h42;
      sweep_seg[1] = 7'h0F;
      sweep_seg[2] = 7'h60;
      sweep_seg[3] = 7'h12;
      slot_seg     = 7'h00;
      for (int k = 0; k < 3 * FRAME; k++) begin
         @(negedge clk);
         g  = (cyc - 1) % FRAME;
         tk = g % CPD;
         sl = g / CPD;
         check_value("sweep_onehot", ($countones(~digit_en) <= 1), 1'b1);
         check_value("sweep_fdone", frame_done, (g == FRAME - 1));
         if (tk < GUARD) check_value("sweep_guard_en", digit_en, 4'hF);
         if (tk == 0) slot_seg = segment;
         else         check_value("sweep_seg_stable", segment, slot_seg);
         if (tk == 4 && k < FRAME) check_value("sweep_digit", segment, sweep_seg[sl]);
      end

      // Leading-zero cases: 0050 and 0000.
      pulse_load(16'h0050);
      goto(3, 7);
      goto(0, 4);
      check_value("0050_d0", segment, 7'h01);
      goto(1, 4);
      check_value("0050_d1", segment, 7'h24);
      goto(2, 4);
      check_value("0050_d2", segment, zero_digit(1'b1));
      goto(3, 4);
      check_value("0050_d3", segment, zero_digit(1'b1));
      check_value("0050_en3", digit_en, 4'h7);
      pulse_load(16'h0000);
      goto(3, 7);
      goto(0, 4);
      check_value("0000_d0", segment, 7'h01);
      check_value("0000_en0", digit_en, 4'hE);
      goto(1, 4);
      check_value("0000_d1", segment, zero_digit(1'b1));
      goto(3, 4);
      check_value("0000_d3", segment, zero_digit(1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
